// File: rtl/apb_wdog.sv
// APB watchdog timer: prescaled down-counter with kick key, lockable control,
// an expiry interrupt and a fixed-length reset-request pulse on the second consecutive expiry.
module apb_wdog #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          CNT_WIDTH      = 32,
  parameter int          PRESCALE       = 16,
  parameter logic [31:0] DEFAULT_LOAD   = 32'h0000_FFFF,
  parameter int          RST_PULSE_LEN  = 8,
  parameter logic [31:0] KICK_KEY       = 32'h5A5A_A5A5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      wdog_irq_o,
  output logic                      wdog_rst_req_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] PULSE_MAX = RW'(RST_PULSE_LEN - 1);

  logic [2:0]           ctrl_r;
  logic [CNT_WIDTH-1:0] load_r;
  logic [CNT_WIDTH-1:0] value_r;
  logic [PW-1:0]        presc_r;
  logic                 irq_pend_r;
  logic                 rst_fired_r;
  logic                 rst_req_r;
  logic [RW-1:0]        pulse_cnt_r;

  logic [2:0]  idx_s;
  logic        addr_hi_s;
  logic        access_s;
  logic        err_s;
  logic        wr_ok_s;
  logic        ctrl_wr_s;
  logic        load_wr_s;
  logic        kick_wr_s;
  logic        status_wr_s;
  logic        en_rise_s;
  logic        kick_s;
  logic        reload_s;
  logic        tick_s;
  logic        expire_s;
  logic        irq_set_s;
  logic        rst_set_s;
  logic [31:0] prdata_s;
  logic        unused_s;

  assign idx_s     = PADDR[4:2];
  // Anything above bit 4 lands beyond the STATUS register and is rejected.
  assign addr_hi_s = |(PADDR >> 3'd5);
  assign unused_s  = ^PADDR[1:0];
  assign access_s  = PSEL & PENABLE;

  // Error decode for the current transfer (address range, read-only, bad key, lock).
  always_comb begin
    err_s = 1'b0;
    if (addr_hi_s || (idx_s > 3'd4)) begin
      err_s = 1'b1;
    end else if (PWRITE) begin
      case (idx_s)
        3'd0:    err_s = ctrl_r[2];
        3'd1:    err_s = ctrl_r[2];
        3'd2:    err_s = 1'b1;
        3'd3:    err_s = (PWDATA != KICK_KEY);
        default: err_s = 1'b0;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  assign wr_ok_s     = access_s & PWRITE & ~err_s;
  assign ctrl_wr_s   = wr_ok_s & (idx_s == 3'd0);
  assign load_wr_s   = wr_ok_s & (idx_s == 3'd1);
  assign kick_wr_s   = wr_ok_s & (idx_s == 3'd3);
  assign status_wr_s = wr_ok_s & (idx_s == 3'd4);

  assign en_rise_s = ctrl_wr_s & PWDATA[0] & ~ctrl_r[0];
  // A kick while disabled is accepted on the bus but leaves the counter alone.
  assign kick_s    = kick_wr_s & ctrl_r[0];
  assign reload_s  = en_rise_s | kick_s;
  assign tick_s    = ctrl_r[0] & (presc_r == PRESC_MAX);
  assign expire_s  = tick_s & (value_r == '0) & ~reload_s;
  assign irq_set_s = expire_s & ~irq_pend_r;
  assign rst_set_s = expire_s & irq_pend_r;

  // Read mux, zero outside a read select or for write-only/unmapped offsets.
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (PSEL && !PWRITE && !addr_hi_s) begin
      case (idx_s)
        3'd0:    prdata_s = {29'h0, ctrl_r};
        3'd1:    prdata_s = 32'(load_r);
        3'd2:    prdata_s = 32'(value_r);
        3'd4:    prdata_s = {30'h0, rst_fired_r, irq_pend_r};
        default: prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  // Control and load registers; LOCK is sticky once written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_r <= 3'b000;
      load_r <= DEFAULT_LOAD[CNT_WIDTH-1:0];
    end else begin
      if (ctrl_wr_s) begin
        ctrl_r <= {ctrl_r[2] | PWDATA[2], PWDATA[1:0]};
      end
      if (load_wr_s) begin
        load_r <= PWDATA[CNT_WIDTH-1:0];
      end
    end
  end

  // Prescaler and down-counter; kick/enable reload has priority over a tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_r <= '0;
      value_r <= DEFAULT_LOAD[CNT_WIDTH-1:0];
    end else if (reload_s) begin
      presc_r <= '0;
      value_r <= load_r;
    end else if (ctrl_r[0]) begin
      if (tick_s) begin
        presc_r <= '0;
        value_r <= (value_r == '0) ? load_r : (value_r - CNT_WIDTH'(1));
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Status flags: W1C, with a same-cycle set taking precedence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_pend_r  <= 1'b0;
      rst_fired_r <= 1'b0;
    end else begin
      irq_pend_r  <= (irq_pend_r  & ~(status_wr_s & PWDATA[0])) | irq_set_s;
      rst_fired_r <= (rst_fired_r & ~(status_wr_s & PWDATA[1])) | rst_set_s;
    end
  end

  // Reset-request pulse; a running pulse ignores further expiries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_req_r   <= 1'b0;
      pulse_cnt_r <= '0;
    end else if (rst_req_r) begin
      if (pulse_cnt_r == '0) begin
        rst_req_r <= 1'b0;
      end else begin
        pulse_cnt_r <= pulse_cnt_r - RW'(1);
      end
    end else if (rst_set_s && ctrl_r[1]) begin
      rst_req_r   <= 1'b1;
      pulse_cnt_r <= PULSE_MAX;
    end
  end

  assign PRDATA         = prdata_s;
  assign PREADY         = 1'b1;
  assign PSLVERR        = access_s & err_s;
  assign wdog_irq_o     = irq_pend_r;
  assign wdog_rst_req_o = rst_req_r;

endmodule
